cla_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for WIDTH-bit operands. It is the successor to the 4-bit combinational CLA. The datapath is split into 4-bit lookahead groups, and a register stage sits after every GRP_PER_STAGE groups, so the carry ripples group-to-group one stage per cycle. Operands are skewed on entry and sums are de-skewed on exit. A valid/ready handshake on both sides lets the block sit in streaming arithmetic paths with backpressure.

---
 rtl/cla_pipe.sv | 179 +++++++++++++++++
 tb/tb_cla_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor.
// Built from 4-bit lookahead groups, with a register after every GRP_PER_STAGE groups.
// Operands are skewed on entry and sums de-skewed on exit.
// One global stall (adv) freezes or advances the whole pipeline.
module cla_pipe #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned GRP_PER_STAGE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_ovf
);

    localparam int unsigned SLICE  = 4 * GRP_PER_STAGE;
    localparam int unsigned STAGES = WIDTH / SLICE;

    if (GRP_PER_STAGE < 1 || WIDTH < 4 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("cla_pipe: WIDTH must be a non-zero multiple of 4*GRP_PER_STAGE");
    end

    typedef struct packed {
        logic [3:0] s;
        logic       co;
        logic       c3;
    } grp_t;

    // One 4-bit lookahead group; c3 is the carry into the group's top bit.
    function automatic grp_t cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        logic       gg;
        logic       pp;
        grp_t       r;
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        gg   = g[3] | (p[3] & (g[2] | (p[2] & (g[1] | (p[1] & g[0])))));
        pp   = &p;
        r.s  = p ^ c;
        r.co = gg | (pp & ci);
        r.c3 = c[3];
        return r;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin;

    // Skew lines: [j][k] holds slice j delayed k+1 cycles.
    logic [SLICE-1:0] a_dly_q [STAGES][STAGES];
    logic [SLICE-1:0] a_dly_d [STAGES][STAGES];
    logic [SLICE-1:0] b_dly_q [STAGES][STAGES];
    logic [SLICE-1:0] b_dly_d [STAGES][STAGES];
    logic [SLICE-1:0] s_dly_q [STAGES][STAGES];
    logic [SLICE-1:0] s_dly_d [STAGES][STAGES];

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic              ovf_q, ovf_d;

    logic [SLICE-1:0]  st_s [STAGES];
    logic [STAGES-1:0] st_co;
    logic              top_c3;

    assign b_eff = i_b ^ {WIDTH{i_sub}};
    assign cin   = i_c ^ i_sub;
    assign adv   = ~vld_q[STAGES-1] | i_ready;

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        logic [SLICE-1:0]       op_a;
        logic [SLICE-1:0]       op_b;
        logic [SLICE-1:0]       sum;
        logic                   ci;
        logic [GRP_PER_STAGE:0] gc;
        logic                   c3;

        if (j == 0) begin : g_entry
            assign op_a = i_a[SLICE-1:0];
            assign op_b = b_eff[SLICE-1:0];
            assign ci   = cin;
        end else begin : g_skewed
            assign op_a = a_dly_q[j][j-1];
            assign op_b = b_dly_q[j][j-1];
            assign ci   = cry_q[j-1];
        end

        // Groups inside one stage ripple their carries combinationally.
        always_comb begin
            grp_t r;
            r     = '0;
            sum   = '0;
            gc    = '0;
            c3    = 1'b0;
            gc[0] = ci;
            for (int k = 0; k < int'(GRP_PER_STAGE); k++) begin
                r             = cla4(op_a[4*k +: 4], op_b[4*k +: 4], gc[k]);
                sum[4*k +: 4] = r.s;
                gc[k+1]       = r.co;
                c3            = r.c3;
            end
        end

        assign st_s[j]  = sum;
        assign st_co[j] = gc[GRP_PER_STAGE];

        if (j == STAGES - 1) begin : g_top
            assign top_c3 = c3;
        end

        assign o_s[j*SLICE +: SLICE] = s_dly_q[j][STAGES-1-j];
    end

    // Next state for skew lines, valid chain, stage carries and overflow.
    always_comb begin
        a_dly_d = a_dly_q;
        b_dly_d = b_dly_q;
        s_dly_d = s_dly_q;
        vld_d   = vld_q;
        for (int j = 0; j < int'(STAGES); j++) begin
            a_dly_d[j][0] = i_a[j*SLICE +: SLICE];
            b_dly_d[j][0] = b_eff[j*SLICE +: SLICE];
            s_dly_d[j][0] = st_s[j];
            for (int k = 1; k < int'(STAGES); k++) begin
                a_dly_d[j][k] = a_dly_q[j][k-1];
                b_dly_d[j][k] = b_dly_q[j][k-1];
                s_dly_d[j][k] = s_dly_q[j][k-1];
            end
        end
        vld_d[0] = i_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            vld_d[k] = vld_q[k-1];
        end
        cry_d = st_co;
        ovf_d = top_c3 ^ st_co[STAGES-1];
    end

    // Whole pipeline shifts together on adv, holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < int'(STAGES); j++) begin
                for (int k = 0; k < int'(STAGES); k++) begin
                    a_dly_q[j][k] <= '0;
                    b_dly_q[j][k] <= '0;
                    s_dly_q[j][k] <= '0;
                end
            end
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            a_dly_q <= a_dly_d;
            b_dly_q <= b_dly_d;
            s_dly_q <= s_dly_d;
            vld_q   <= vld_d;
            cry_q   <= cry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready = adv;
    assign o_valid = vld_q[STAGES-1];
    assign o_c     = cry_q[STAGES-1];
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: table vectors, streams with backpressure and reset,
// plus random sweeps of a 32-bit/2-group and an 8-bit/2-group instance.
module tb_cla_pipe;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        ovf;
        int          cyc;
    } sb_t;

    typedef struct {
        res_t r;
        int   cyc;
    } sw_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit, 1 group per stage
    logic        rst0, v0, c0, sub0, i_ready0;
    logic [15:0] a0, b0;
    logic        o_ready0, o_valid0, o_c0, o_ovf0;
    logic [15:0] o_s0;

    // sweep instances
    logic        rst12, v1, c1, sub1, v2, c2, sub2;
    logic [31:0] a1, b1;
    logic [7:0]  a2, b2;
    logic        o_ready1, o_valid1, o_c1, o_ovf1;
    logic [31:0] o_s1;
    logic        o_ready2, o_valid2, o_c2, o_ovf2;
    logic [7:0]  o_s2;

    cla_pipe #(.WIDTH(16), .GRP_PER_STAGE(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst0), .i_valid(v0), .o_ready(o_ready0),
        .i_a(a0), .i_b(b0), .i_c(c0), .i_sub(sub0),
        .o_valid(o_valid0), .i_ready(i_ready0), .o_s(o_s0), .o_c(o_c0), .o_ovf(o_ovf0)
    );

    cla_pipe #(.WIDTH(32), .GRP_PER_STAGE(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst12), .i_valid(v1), .o_ready(o_ready1),
        .i_a(a1), .i_b(b1), .i_c(c1), .i_sub(sub1),
        .o_valid(o_valid1), .i_ready(1'b1), .o_s(o_s1), .o_c(o_c1), .o_ovf(o_ovf1)
    );

    cla_pipe #(.WIDTH(8), .GRP_PER_STAGE(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst12), .i_valid(v2), .o_ready(o_ready2),
        .i_a(a2), .i_b(b2), .i_c(c2), .i_sub(sub2),
        .o_valid(o_valid2), .i_ready(1'b1), .o_s(o_s2), .o_c(o_c2), .o_ovf(o_ovf2)
    );

    // Reference: plain wide addition with the subtract conditioning applied.
    function automatic res_t model(input int unsigned w, input logic [63:0] a,
                                   input logic [63:0] b, input logic ci, input logic sub);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] be;
        logic [63:0] am;
        res_t        r;
        mask  = (64'd1 << w) - 64'd1;
        am    = a & mask;
        be    = (sub ? ~b : b) & mask;
        full  = {1'b0, am} + {1'b0, be} + {64'd0, ci ^ sub};
        r.s   = full[63:0] & mask;
        r.c   = full[w];
        r.ovf = (am[w-1] == be[w-1]) && (r.s[w-1] != am[w-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard for the 16-bit instance.
    sb_t         sb0[$];
    logic [15:0] cur_s;
    logic        cur_c, cur_ovf;
    logic        chk_lat = 1'b1;
    int          n_out = 0;
    int          last_out = 0;

    always @(negedge clk) begin
        sb_t e;
        if (rst0) begin
            sb0.delete();
        end else begin
            if (v0 && o_ready0) sb0.push_back('{cur_s, cur_c, cur_ovf, cyc});
            if (o_valid0 && i_ready0) begin
                if (sb0.size() == 0) begin
                    chk("dut16 spurious output", 64'(o_s0), 64'hx);
                end else begin
                    e = sb0.pop_front();
                    chk("dut16 result", 64'({o_c0, o_ovf0, o_s0}), 64'({e.c, e.ovf, e.s}));
                    if (chk_lat) chk("dut16 latency", 64'(cyc - e.cyc), 64'd4);
                    n_out++;
                    last_out = cyc;
                end
            end
        end
    end

    // Scoreboards for the sweep instances (always ready downstream).
    sw_t q1[$];
    sw_t q2[$];
    logic sweep_go = 1'b0;
    logic sweep_done = 1'b0;

    always @(negedge clk) begin
        sw_t e;
        if (!rst12) begin
            if (v1 && o_ready1) q1.push_back('{model(32, 64'(a1), 64'(b1), c1, sub1), cyc});
            if (v2 && o_ready2) q2.push_back('{model(8, 64'(a2), 64'(b2), c2, sub2), cyc});
            if (o_valid1) begin
                if (q1.size() == 0) chk("dut32 spurious output", 64'(o_s1), 64'hx);
                else begin
                    e = q1.pop_front();
                    chk("dut32 result", 64'({o_c1, o_ovf1, o_s1}),
                        64'({e.r.c, e.r.ovf, e.r.s[31:0]}));
                    chk("dut32 latency", 64'(cyc - e.cyc), 64'd4);
                end
            end
            if (o_valid2) begin
                if (q2.size() == 0) chk("dut8 spurious output", 64'(o_s2), 64'hx);
                else begin
                    e = q2.pop_front();
                    chk("dut8 result", 64'({o_c2, o_ovf2, o_s2}),
                        64'({e.r.c, e.r.ovf, e.r.s[7:0]}));
                    chk("dut8 latency", 64'(cyc - e.cyc), 64'd1);
                end
            end
        end
    end

    initial begin
        v1 = 1'b0; v2 = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0; sub1 = 1'b0;
        a2 = '0; b2 = '0; c2 = 1'b0; sub2 = 1'b0;
        wait (sweep_go);
        @(posedge clk); #1;
        for (int n = 0; n < 10000; n++) begin
            v1   = ($urandom_range(0, 7) != 0);
            a1   = $urandom;
            b1   = $urandom;
            c1   = 1'($urandom_range(0, 1));
            sub1 = 1'($urandom_range(0, 1));
            v2   = ($urandom_range(0, 7) != 0);
            a2   = 8'($urandom);
            b2   = 8'($urandom);
            c2   = 1'($urandom_range(0, 1));
            sub2 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        v1 = 1'b0; v2 = 1'b0;
        repeat (10) @(posedge clk);
        #1 sweep_done = 1'b1;
    end

    // Present one vector and hold it until the block takes it.
    task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic sub, input logic [15:0] es, input logic ec, input logic eo);
        logic acc;
        int   t;
        a0 = a; b0 = b; c0 = c; sub0 = sub; v0 = 1'b1;
        cur_s = es; cur_c = ec; cur_ovf = eo;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = o_ready0;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) chk("dut16 accept timeout", 64'd0, 64'd1);
        v0 = 1'b0;
    endtask

    task automatic drain0();
        for (int t = 0; t < 60 && sb0.size() != 0; t++) @(posedge clk);
        #1;
        chk("dut16 drain", 64'(sb0.size()), 64'd0);
    endtask

    vec_t        tbl[8];
    logic [15:0] ra[8], rb[8];
    logic        rc[8], rs[8];
    res_t        rr[8];
    int          base;
    int          n_before;

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst0 = 1'b1; rst12 = 1'b1; v0 = 1'b0; i_ready0 = 1'b1;
        a0 = '0; b0 = '0; c0 = 1'b0; sub0 = 1'b0;
        cur_s = '0; cur_c = 1'b0; cur_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst0 = 1'b0; rst12 = 1'b0;
        @(negedge clk);
        chk("reset o_valid", 64'(o_valid0), 64'd0);
        chk("reset o_s", 64'(o_s0), 64'd0);
        chk("reset o_c/o_ovf", 64'({o_c0, o_ovf0}), 64'd0);
        chk("reset o_ready", 64'(o_ready0), 64'd1);
        sweep_go = 1'b1;
        @(posedge clk); #1;

        // Table vectors, back to back.
        for (int i = 0; i < 8; i++)
            send0(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub, tbl[i].s, tbl[i].co, tbl[i].ovf);
        drain0();

        // 8 random vectors streamed with i_ready held high.
        n_before = n_out;
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom); rb[i] = 16'($urandom);
            rc[i] = 1'($urandom_range(0, 1)); rs[i] = 1'($urandom_range(0, 1));
            rr[i] = model(16, 64'(ra[i]), 64'(rb[i]), rc[i], rs[i]);
        end
        for (int i = 0; i < 8; i++)
            send0(ra[i], rb[i], rc[i], rs[i], rr[i].s[15:0], rr[i].c, rr[i].ovf);
        drain0();
        chk("stream count", 64'(n_out - n_before), 64'd8);

        // Same stream with i_ready low in cycles 6..8.
        chk_lat  = 1'b0;
        n_before = n_out;
        base     = cyc;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send0(ra[i], rb[i], rc[i], rs[i], rr[i].s[15:0], rr[i].c, rr[i].ovf);
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    i_ready0 = !(k >= 6 && k <= 8);
                    if (!i_ready0) begin
                        @(negedge clk);
                        chk("stall o_ready", 64'(o_ready0), 64'd0);
                        chk("stall o_valid", 64'(o_valid0), 64'd1);
                        chk("stall frozen o_s", 64'(o_s0), 64'(rr[2].s[15:0]));
                    end
                    @(posedge clk); #1;
                end
                i_ready0 = 1'b1;
            end
        join
        drain0();
        chk_lat = 1'b1;
        chk("stall count", 64'(n_out - n_before), 64'd8);
        chk("stall last result cycle", 64'(last_out - base), 64'd14);

        // Four vectors with reset in the third cycle.
        n_before = n_out;
        for (int i = 0; i < 4; i++) begin
            a0 = ra[i]; b0 = rb[i]; c0 = rc[i]; sub0 = rs[i]; v0 = 1'b1;
            cur_s = rr[i].s[15:0]; cur_c = rr[i].c; cur_ovf = rr[i].ovf;
            rst0 = (i == 2);
            if (i == 3) begin
                @(negedge clk);
                chk("post-reset o_valid", 64'(o_valid0), 64'd0);
                chk("post-reset outputs", 64'({o_c0, o_ovf0, o_s0}), 64'd0);
                chk("post-reset o_ready", 64'(o_ready0), 64'd1);
            end
            @(posedge clk); #1;
        end
        v0 = 1'b0;
        drain0();
        chk("reset-test output count", 64'(n_out - n_before), 64'd1);

        for (int t = 0; t < 20000 && !sweep_done; t++) @(posedge clk);
        #1;
        chk("sweep finished", 64'(sweep_done), 64'd1);
        chk("sweep32 queue empty", 64'(q1.size()), 64'd0);
        chk("sweep8 queue empty", 64'(q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
